uart_tx_fifo_drain: RTL
=======================

// Module: uart_tx_fifo_drain
// PURPOSE
//  UART transmitter that reads the FIFO's dequeue side and serializes each byte onto a single tx line.
//  Sits between the transmit FIFO (dequeue side) and the pad.
//  Pulls one word per frame with a single-cycle dequeue request.
//  Frame: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); must be >= 2
//  DATA_BITS     8    payload width; must equal the FIFO DATA_BITS
//  PARITY_EN     0    1 = append parity bit after data
//  PARITY_ODD    0    0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
//  STOP_BITS     1    number of stop bits, 1 or 2
// PORTS
//  clk                 in   1          single clock
//  reset               in   1          synchronous, active-high
//  fifo_dequeue        in   DATA_BITS  word from FIFO, valid when fifo_dequeue_valid=1
//  fifo_dequeue_valid  in   1          FIFO read strobe, arrives 1 cycle after request
//  fifo_is_empty       in   1          FIFO empty flag
//  fifo_req_dequeue    out  1          one-cycle dequeue request
//  tx                  out  1          serial line, idle high, registered
//  busy                out  1          high from REQ until frame end
//  tx_done             out  1          one-cycle pulse in final cycle of last stop bit
// BEHAVIOUR
//  Reset values: tx=1, busy=0, tx_done=0, fifo_req_dequeue=0.
//  State machine: IDLE, REQ, WAIT_DATA, START, DATA, PARITY, STOP; reset goes to IDLE.
//  Counters: bit counter 0..DATA_BITS-1; baud counter 0..CLKS_PER_BIT-1; both cleared on every state entry.
//  State transitions:
//  - IDLE: if !fifo_is_empty -> REQ.
//  - REQ: fifo_req_dequeue=1 (combinational from state, exactly one cycle) -> WAIT_DATA.
//  - WAIT_DATA, valid=1: latch fifo_dequeue into shift register, compute parity, -> START.
//  - WAIT_DATA, valid=0 for 2 cycles (FIFO reset/underflow): -> IDLE, no frame sent, no tx_done.
//  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
//  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shift right; after DATA_BITS bits -> PARITY if PARITY_EN else STOP.
//  - PARITY: tx = ^data (even) or ~^data (odd) for CLKS_PER_BIT cycles -> STOP.
//  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; tx_done in last cycle -> IDLE.
//  Latency: first IDLE cycle with !fifo_is_empty = k; REQ at k+1; WAIT_DATA at k+2; tx falls at k+3.
//  Frame length: (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
//  Back-to-back: min 3 idle-high cycles between frames (IDLE, REQ, WAIT_DATA); no prefetch.
//  tx is a register; it changes only on state/bit boundaries, glitch-free.
//  busy=1 in every state except IDLE.
//  fifo_req_dequeue is never asserted while fifo_is_empty was sampled high in IDLE, nor outside REQ.
//  Reset mid-frame: next edge tx=1, state IDLE, partial byte discarded, no tx_done.
//  Stray fifo_dequeue_valid outside WAIT_DATA: ignored.
// STRUCTURE
//  uart_pkg: tx_state_t enum; DEFAULT_CLKS_PER_BIT; function parity_bit(data, odd).
//  Sub-module uart_baud_counter: counts 0..CLKS_PER_BIT-1; clear input; bit_end pulse output.
//  Top: FSM, shift register, bit counter, parity register, tx register.
// TESTING  (CLKS_PER_BIT=4 unless noted)
//  - Reset: hold reset 3 cycles -> tx=1, busy=0, tx_done=0, fifo_req_dequeue=0.
//    Assert reset mid-DATA -> tx=1 next cycle, no tx_done.
//  - 8N1 0xA5, FIFO model 1-cycle valid:
//    fifo_req_dequeue high exactly 1 cycle; tx falls 3 cycles after empty deasserts.
//    tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done at cycle 40 of frame.
//  - Parity 0xA5: PARITY_EN=1, PARITY_ODD=0 -> parity bit 0; PARITY_ODD=1 -> parity bit 1.
//    Frame 44 cycles.
//  - 2 stop bits, 0x00: tx low 36 cycles (start + 8 data), then high 8 cycles; tx_done in last high cycle.
//  - Back-to-back 0x55, 0xFF queued: two frames, 3-cycle idle gap, exactly 2 requests, 2 tx_done pulses.
//  - Missing valid: after request, FIFO withholds valid 2 cycles -> return to IDLE, tx stays 1, busy drops.

Source files
------------

// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared types and helpers for the FIFO-draining UART transmitter.
package uart_tx_fifo_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_DATA,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int PARITY_MAX_BITS      = 32;

    // Callers zero-extend narrower payloads; extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [PARITY_MAX_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the last cycle of each bit.
module uart_tx_fifo_drain_baud_counter
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clear,
    output logic [CW-1:0] o_count,
    output logic          o_bit_end
);

    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_bit_end = (r_count == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter pulling one word per frame from the TX FIFO dequeue side and driving the pad.
// state      | meaning
// IDLE       | line high, waiting for a non-empty FIFO
// REQ        | one-cycle dequeue request
// WAIT_DATA  | waiting up to 2 cycles for the FIFO read strobe
// START      | start bit (low)
// DATA       | payload bits, LSB first
// PARITY     | optional parity bit
// STOP       | STOP_BITS stop bits (high); tx_done in the final cycle
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DATA_BITS-1:0] i_fifo_dequeue,
    input  logic                 i_fifo_dequeue_valid,
    input  logic                 i_fifo_is_empty,
    output logic                 o_fifo_req_dequeue,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS + STOP_BITS);

    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(1);

    tx_state_t            r_state, w_state_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [BW-1:0]        r_bit_cnt, w_bit_cnt_next;
    logic                 r_parity, w_parity_next;
    logic                 r_tx, w_tx_next;
    logic                 w_tx_done;
    logic                 w_baud_clear;
    logic                 w_bit_end;
    logic [CW-1:0]        w_baud_count;

    uart_tx_fifo_drain_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_baud_clear),
        .o_count   (w_baud_count),
        .o_bit_end (w_bit_end)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_parity  <= w_parity_next;
            r_tx      <= w_tx_next;
        end
    end

    // The tx register is loaded with the value of the state being entered, so it toggles only on boundaries.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_parity_next  = r_parity;
        w_tx_next      = r_tx;
        w_tx_done      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_next = 1'b1;
                if (!i_fifo_is_empty) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                w_state_next = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (i_fifo_dequeue_valid) begin
                    w_shift_next  = i_fifo_dequeue;
                    w_parity_next = parity_bit(PARITY_MAX_BITS'(i_fifo_dequeue), PARITY_ODD != 0);
                    w_tx_next     = 1'b0;
                    w_state_next  = ST_START;
                end else if (w_baud_count == WAIT_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_tx_next    = r_shift[0];
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == LAST_DATA) begin
                        if (PARITY_EN != 0) begin
                            w_tx_next    = r_parity;
                            w_state_next = ST_PARITY;
                        end else begin
                            w_tx_next    = 1'b1;
                            w_state_next = ST_STOP;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                        w_tx_next      = w_shift_next[0];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_tx_next    = 1'b1;
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == LAST_STOP) begin
                        w_tx_done    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_tx_next    = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_state_next != r_state) begin
            w_bit_cnt_next = '0;
        end
    end

    assign w_baud_clear       = (w_state_next != r_state);
    assign o_fifo_req_dequeue = (r_state == ST_REQ);
    assign o_busy             = (r_state != ST_IDLE);
    assign o_tx               = r_tx;
    // A reset landing on the last stop cycle aborts the frame, so suppress the pulse.
    assign o_tx_done          = w_tx_done && !i_reset;

endmodule
